// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time against an internal word RAM,
// completing after WAIT_CYCLES wait states with a one-cycle complete_data pulse.
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DMem_en,
  input  logic [15:0] DMem_addr,
  input  logic        DMem_rd,
  input  logic [15:0] DMem_din,
  output logic [15:0] DMem_dout,
  output logic        complete_data,
  output logic        busy,
  output logic        addr_err
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        accept;
  logic        access;

  logic [15:0] req_addr;
  logic        req_rd;
  logic [15:0] req_din;

  logic [15:0] acc_addr;
  logic        acc_rd;
  logic [15:0] acc_din;
  logic        acc_ok;

  logic [15:0] mem [DEPTH];

  // Upper address bits must be zero; nonzero bits flag an error rather than alias.
  function automatic logic addr_in_range(input logic [15:0] a);
    return (a >> ADDR_W) == 16'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    access    = 1'b0;
    case (state)
      S_IDLE: begin
        if (DMem_en) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            state_nxt = S_RESP;
          end else begin
            cnt_nxt   = WAIT_LD;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) begin
          access    = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so it must
  // use the live bus rather than the not-yet-loaded request registers.
  always_comb begin
    busy = (state != S_IDLE);
    if (state == S_IDLE) begin
      acc_addr = DMem_addr;
      acc_rd   = DMem_rd;
      acc_din  = DMem_din;
    end else begin
      acc_addr = req_addr;
      acc_rd   = req_rd;
      acc_din  = req_din;
    end
    acc_ok = addr_in_range(acc_addr);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= DMem_addr;
      req_rd   <= DMem_rd;
      req_din  <= DMem_din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      DMem_dout     <= 16'h0000;
      complete_data <= 1'b0;
      addr_err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 16'h0000;
    end else begin
      complete_data <= access;
      addr_err      <= access & ~acc_ok;
      if (access) begin
        if (!acc_ok) begin
          DMem_dout <= 16'h0000;
        end else if (acc_rd) begin
          DMem_dout <= mem[acc_addr[ADDR_W-1:0]];
        end else begin
          mem[acc_addr[ADDR_W-1:0]] <= acc_din;
          DMem_dout                 <= acc_din;
        end
      end
    end
  end

endmodule
